// File: rtl/char_draw.sv
// char_draw: per-pixel 8x16 character-cell renderer with registered RGB and cell index.
// An 8x8 font ROM is shown with every row doubled vertically.
module char_draw #(
  parameter logic [23:0] FG_RGB  = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB  = 24'h000080,
  parameter logic [23:0] OUT_RGB = 24'h000000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [9:0] box_x,
  input  logic [8:0] box_y,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [7:0] char,
  output logic [7:0] tft_r,
  output logic [7:0] tft_g,
  output logic [7:0] tft_b,
  output logic [6:0] idx
);

  localparam int unsigned CW = 11;

  logic [CW-1:0]   x_w, y_w, bx_w, by_w;
  logic            in_box_c;
  logic [2:0]      dx_c;
  logic [3:0]      dy_c;
  logic [7:0][7:0] glyph_c;
  logic [7:0]      row_c;
  logic            bit_c;
  logic [23:0]     rgb_c;
  logic [6:0]      idx_c;

  // IBM PC 8x8 glyphs, row 0 in the top byte, MSB is the leftmost pixel
  function automatic logic [63:0] font_glyph(input logic [7:0] code);
    case (code)
      8'd1:  font_glyph = 64'h3078CCCCFCCCCC00; // A
      8'd2:  font_glyph = 64'hFC66667C6666FC00; // B
      8'd3:  font_glyph = 64'h3C66C0C0C0663C00; // C
      8'd4:  font_glyph = 64'hF86C6666666CF800; // D
      8'd5:  font_glyph = 64'hFE6268786862FE00; // E
      8'd6:  font_glyph = 64'hFE6268786860F000; // F
      8'd7:  font_glyph = 64'h3C66C0C0CE663E00; // G
      8'd8:  font_glyph = 64'hCCCCCCFCCCCCCC00; // H
      8'd9:  font_glyph = 64'h7830303030307800; // I
      8'd10: font_glyph = 64'h1E0C0C0CCCCC7800; // J
      8'd11: font_glyph = 64'hE6666C786C66E600; // K
      8'd12: font_glyph = 64'hF06060606266FE00; // L
      8'd13: font_glyph = 64'hC6EEFEFED6C6C600; // M
      8'd14: font_glyph = 64'hC6E6F6DECEC6C600; // N
      8'd15: font_glyph = 64'h386CC6C6C66C3800; // O
      8'd16: font_glyph = 64'hFC66667C6060F000; // P
      8'd17: font_glyph = 64'h78CCCCCCDC781C00; // Q
      8'd18: font_glyph = 64'hFC66667C6C66E600; // R
      8'd19: font_glyph = 64'h78CCE0701CCC7800; // S
      8'd20: font_glyph = 64'hFCB4303030307800; // T
      8'd21: font_glyph = 64'hCCCCCCCCCCCCFC00; // U
      8'd22: font_glyph = 64'hCCCCCCCCCC783000; // V
      8'd23: font_glyph = 64'hC6C6C6D6FEEEC600; // W
      8'd24: font_glyph = 64'hC6C66C38386CC600; // X
      8'd25: font_glyph = 64'hCCCCCC7830307800; // Y
      8'd26: font_glyph = 64'hFEC68C183266FE00; // Z
      8'd27: font_glyph = 64'h7CC6CEDEF6E67C00; // 0
      8'd28: font_glyph = 64'h307030303030FC00; // 1
      8'd29: font_glyph = 64'h78CC0C3860CCFC00; // 2
      8'd30: font_glyph = 64'h78CC0C380CCC7800; // 3
      8'd31: font_glyph = 64'h1C3C6CCCFE0C1E00; // 4
      8'd32: font_glyph = 64'hFCC0F80C0CCC7800; // 5
      8'd33: font_glyph = 64'h3860C0F8CCCC7800; // 6
      8'd34: font_glyph = 64'hFCCC0C1830303000; // 7
      8'd35: font_glyph = 64'h78CCCC78CCCC7800; // 8
      8'd36: font_glyph = 64'h78CCCC7C0C187000; // 9
      default: font_glyph = 64'h0;              // space and unused codes
    endcase
  endfunction

  // In-box test in 11 bits so box_x+7 / box_y+15 never wrap
  always_comb begin
    x_w      = CW'(x);
    y_w      = CW'(y);
    bx_w     = CW'(box_x);
    by_w     = CW'(box_y);
    in_box_c = (x_w >= bx_w) && (x_w <= bx_w + 11'd7) &&
               (y_w >= by_w) && (y_w <= by_w + 11'd15);
    dx_c     = 3'(x_w - bx_w);
    dy_c     = 4'(y_w - by_w);
  end

  // Glyph lookup, colour select and cell index
  always_comb begin
    glyph_c = font_glyph(char);
    row_c   = glyph_c[3'(3'd7 - dy_c[3:1])];
    bit_c   = row_c[3'(3'd7 - dx_c)];
    rgb_c   = OUT_RGB;
    idx_c   = 7'd0;
    if (in_box_c) begin
      rgb_c = bit_c ? FG_RGB : BG_RGB;
      idx_c = {dy_c, dx_c};
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tft_r <= 8'd0;
      tft_g <= 8'd0;
      tft_b <= 8'd0;
      idx   <= 7'd0;
    end else begin
      tft_r <= rgb_c[23:16];
      tft_g <= rgb_c[15:8];
      tft_b <= rgb_c[7:0];
      idx   <= idx_c;
    end
  end

endmodule

// File: tb/tb_char_draw.sv
// tb_char_draw: vector table, directed corner sequences, random model check and frame sweep.
module tb_char_draw;

  logic       clk = 1'b0;
  logic       rstb;
  logic [9:0] box_x, x;
  logic [8:0] box_y, y;
  logic [7:0] char;
  logic [7:0] tft_r, tft_g, tft_b;
  logic [6:0] idx;

  int total = 0;
  int bad   = 0;

  char_draw dut (
    .clk(clk), .rstb(rstb), .box_x(box_x), .box_y(box_y), .x(x), .y(y),
    .char(char), .tft_r(tft_r), .tft_g(tft_g), .tft_b(tft_b), .idx(idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  bx;
    logic [8:0]  by;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [7:0]  ch;
    logic [23:0] rgb;
    logic [6:0]  ix;
  } vec_t;

  vec_t vecs[$];

  // Reference glyph rows (IBM PC 8x8), top row in the high byte
  logic [63:0] font_tab [0:36] = '{
    64'h0,
    64'h3078CCCCFCCCCC00, 64'hFC66667C6666FC00, 64'h3C66C0C0C0663C00, 64'hF86C6666666CF800,
    64'hFE6268786862FE00, 64'hFE6268786860F000, 64'h3C66C0C0CE663E00, 64'hCCCCCCFCCCCCCC00,
    64'h7830303030307800, 64'h1E0C0C0CCCCC7800, 64'hE6666C786C66E600, 64'hF06060606266FE00,
    64'hC6EEFEFED6C6C600, 64'hC6E6F6DECEC6C600, 64'h386CC6C6C66C3800, 64'hFC66667C6060F000,
    64'h78CCCCCCDC781C00, 64'hFC66667C6C66E600, 64'h78CCE0701CCC7800, 64'hFCB4303030307800,
    64'hCCCCCCCCCCCCFC00, 64'hCCCCCCCCCC783000, 64'hC6C6C6D6FEEEC600, 64'hC6C66C38386CC600,
    64'hCCCCCC7830307800, 64'hFEC68C183266FE00,
    64'h7CC6CEDEF6E67C00, 64'h307030303030FC00, 64'h78CC0C3860CCFC00, 64'h78CC0C380CCC7800,
    64'h1C3C6CCCFE0C1E00, 64'hFCC0F80C0CCC7800, 64'h3860C0F8CCCC7800, 64'hFCCC0C1830303000,
    64'h78CCCC78CCCC7800, 64'h78CCCC7C0C187000
  };

  // Behavioural model: plain integer geometry and shifts on the glyph word
  function automatic void model(input int bx, input int by, input int px, input int py,
                                input int ch, output logic [23:0] rgb, output logic [6:0] ix);
    int dx, dy, row, pbit;
    if (px >= bx && px <= bx + 7 && py >= by && py <= by + 15) begin
      dx   = px - bx;
      dy   = py - by;
      row  = (ch <= 36) ? int'((font_tab[ch] >> (8 * (7 - dy / 2))) & 64'hFF) : 0;
      pbit = (row >> (7 - dx)) & 1;
      rgb  = (pbit == 1) ? 24'hFFFFFF : 24'h000080;
      ix   = 7'(dy * 8 + dx);
    end else begin
      rgb = 24'h000000;
      ix  = 7'd0;
    end
  endfunction

  function automatic vec_t mk(input string n, input int bx, input int by, input int px,
                              input int py, input int ch, input logic [23:0] rgb, input int ix);
    vec_t v;
    v.name = n; v.bx = 10'(bx); v.by = 9'(by); v.px = 10'(px); v.py = 9'(py);
    v.ch = 8'(ch); v.rgb = rgb; v.ix = 7'(ix);
    return v;
  endfunction

  task automatic check(input string n, input logic [23:0] exp_rgb, input logic [6:0] exp_ix);
    total++;
    if ({tft_r, tft_g, tft_b} !== exp_rgb || idx !== exp_ix) begin
      bad++;
      $display("FAIL %s: got rgb=%06h idx=%0d, want rgb=%06h idx=%0d",
               n, {tft_r, tft_g, tft_b}, idx, exp_rgb, exp_ix);
    end
  endtask

  // Drive one pixel on the falling edge, leave the DUT sampled 1 time unit past the rising edge
  task automatic apply(input int bx, input int by, input int px, input int py, input int ch);
    @(negedge clk);
    box_x = 10'(bx); box_y = 9'(by); x = 10'(px); y = 9'(py); char = 8'(ch);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] e_rgb;
    logic [6:0]  e_ix;
    int bx, by, px, py, ch, non_out, fg, exp_fg;

    // Asynchronous reset with arbitrary inputs
    rstb = 1'b0; box_x = 10'd3; box_y = 9'd4; x = 10'd5; y = 9'd6; char = 8'd1;
    #23;
    check("reset_hold", 24'h0, 7'd0);

    @(negedge clk);
    rstb = 1'b1;
    apply(0, 0, 500, 0, 1);
    check("after_reset_out", 24'h000000, 7'd0);

    // Table of fixed vectors
    vecs.push_back(mk("a_x2_y0",      0,   0,   2,   0,   1, 24'hFFFFFF, 2));
    vecs.push_back(mk("a_x0_y0",      0,   0,   0,   0,   1, 24'h000080, 0));
    vecs.push_back(mk("a_x5_y8",      0,   0,   5,   8,   1, 24'hFFFFFF, 69));
    vecs.push_back(mk("a_x6_y9",      0,   0,   6,   9,   1, 24'h000080, 78));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("a_row14_x%0d", i), 0, 0, i, 14, 1, 24'h000080, 112 + i));
    vecs.push_back(mk("dbl_y2",       0,   0,   3,   2,   1, 24'hFFFFFF, 19));
    vecs.push_back(mk("dbl_y3",       0,   0,   3,   3,   1, 24'hFFFFFF, 27));
    vecs.push_back(mk("clip_478_264", 476, 264, 478, 264, 1, 24'hFFFFFF, 2));
    vecs.push_back(mk("clip_479_271", 476, 264, 479, 271, 1, 24'h000080, 59));
    vecs.push_back(mk("out_left",     100, 50,  99,  50,  1, 24'h000000, 0));
    vecs.push_back(mk("out_right",    100, 50,  108, 50,  1, 24'h000000, 0));
    vecs.push_back(mk("out_below",    100, 50,  100, 66,  1, 24'h000000, 0));
    vecs.push_back(mk("space",        100, 50,  100, 50,  0, 24'h000080, 0));
    vecs.push_back(mk("code200",      100, 50,  103, 57,  200, 24'h000080, 59));
    vecs.push_back(mk("digit0",       100, 50,  101, 50,  27, 24'hFFFFFF, 1));
    vecs.push_back(mk("bottom_in",    100, 50,  107, 65,  1, 24'h000080, 127));
    foreach (vecs[i]) begin
      apply(vecs[i].bx, vecs[i].by, vecs[i].px, vecs[i].py, vecs[i].ch);
      check(vecs[i].name, vecs[i].rgb, vecs[i].ix);
    end

    // Mid-run asynchronous reset, then first valid output one edge after release
    apply(0, 0, 2, 0, 1);
    check("pre_reset_fg", 24'hFFFFFF, 7'd2);
    #2;
    rstb = 1'b0;
    #1;
    check("async_reset", 24'h0, 7'd0);
    @(posedge clk); #1;
    check("reset_held_edge", 24'h0, 7'd0);
    @(negedge clk);
    rstb = 1'b1;
    apply(0, 0, 5, 8, 1);
    check("first_after_release", 24'hFFFFFF, 7'd69);

    // Randomised pixels near random boxes against the model
    for (int i = 0; i < 400; i++) begin
      bx = int'($urandom_range(0, 479));
      by = int'($urandom_range(0, 271));
      px = bx + int'($urandom_range(0, 11)) - 2;
      py = by + int'($urandom_range(0, 19)) - 2;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      if (px > 1023) px = 1023;
      if (py > 511) py = 511;
      ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 37));
      apply(bx, by, px, py, ch);
      model(bx, by, px, py, ch, e_rgb, e_ix);
      check($sformatf("rand%0d", i), e_rgb, e_ix);
    end

    // Scan the top band of the frame (holds the whole cell) and count coloured pixels
    non_out = 0;
    fg      = 0;
    for (int yy = 0; yy < 24; yy++) begin
      for (int xx = 0; xx < 480; xx++) begin
        apply(0, 0, xx, yy, 1);
        if ({tft_r, tft_g, tft_b} != 24'h000000) non_out++;
        if ({tft_r, tft_g, tft_b} == 24'hFFFFFF) fg++;
      end
    end
    exp_fg = 2 * $countones(font_tab[1]);
    total++;
    if (non_out != 128) begin
      bad++;
      $display("FAIL sweep_cell_pixels: got %0d, want 128", non_out);
    end
    total++;
    if (fg != exp_fg) begin
      bad++;
      $display("FAIL sweep_fg_pixels: got %0d, want %0d", fg, exp_fg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
